// File: rtl/const_pack.sv
// Shared constants for the emulator control blocks.
package const_pack;

  localparam int FRAME_CNT_W = 16;
  localparam int IN_W_DEF    = 16;

endpackage

// File: rtl/emu_seq_pack.sv
// Chunk-sequencer state encoding and default frame geometry.
package emu_seq_pack;

  localparam int N_CHUNKS_DEF = 4;
  localparam int CHUNK_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_COMMIT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/emu_chunk_select.sv
// Picks one CHUNK_W slice out of the history word; index 0 is the most significant chunk.
module emu_chunk_select #(
  parameter int N_CHUNKS = 4,
  parameter int CHUNK_W  = 8,
  localparam int HIST_W  = N_CHUNKS * CHUNK_W,
  localparam int IDX_W   = $clog2(N_CHUNKS)
) (
  input  logic [HIST_W-1:0]  history,
  input  logic [IDX_W-1:0]   chunk_idx,
  output logic [CHUNK_W-1:0] chunk
);

  logic [HIST_W-1:0] shifted;

  always_comb begin
    shifted = history >> (CHUNK_W * (N_CHUNKS - 1 - int'(chunk_idx)));
    chunk   = shifted[CHUNK_W-1:0];
  end

endmodule

// File: rtl/emu_chunk_sequencer.sv
// Steps the slices through N_CHUNKS history chunks per input beat, then settles and commits.
//   state  | meaning
//   WAIT   | idle, waiting for an accepted beat
//   ACCUM  | presenting chunk 0..N_CHUNKS-1 to the slices
//   SETTLE | one quiet cycle before the result is taken
//   COMMIT | sample/write strobe, may accept the next beat
module emu_chunk_sequencer
  import const_pack::*, emu_seq_pack::*;
#(
  parameter int N_CHUNKS = N_CHUNKS_DEF,
  parameter int CHUNK_W  = CHUNK_W_DEF,
  parameter int IN_W     = IN_W_DEF,
  parameter int HIST_W   = N_CHUNKS * CHUNK_W,
  localparam int IDX_W   = $clog2(N_CHUNKS),
  localparam int FC_W    = IDX_W + 2
) (
  input  logic                   emu_clk,
  input  logic                   emu_rst_n,
  input  logic                   enable,
  input  logic                   flush,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [CHUNK_W-1:0]     chunk,
  output logic [IDX_W-1:0]       chunk_idx,
  output logic                   incr_sum,
  output logic                   sample_ctl,
  output logic                   write_output,
  output logic                   clk_adc_val,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  seq_state_t             state, state_nxt;
  logic [IDX_W-1:0]       cnt;
  logic [HIST_W-1:0]      history;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FC_W-1:0]        frame_cyc;
  logic                   accept;

  // Reset term keeps in_ready low while the block is held in reset.
  assign in_ready = emu_rst_n && enable && !flush &&
                    (state == ST_WAIT || state == ST_COMMIT);
  assign accept    = in_valid && in_ready;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) state <= ST_WAIT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_WAIT;
    end else begin
      case (state)
        ST_WAIT:   if (accept) state_nxt = ST_ACCUM;
        ST_ACCUM:  if (cnt == IDX_W'(N_CHUNKS - 1)) state_nxt = ST_SETTLE;
        ST_SETTLE: state_nxt = ST_COMMIT;
        ST_COMMIT: state_nxt = accept ? ST_ACCUM : ST_WAIT;
        default:   state_nxt = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    chunk_idx    = '0;
    incr_sum     = 1'b0;
    sample_ctl   = 1'b0;
    write_output = 1'b0;
    busy         = (state != ST_WAIT);
    frame_cyc    = '0;
    case (state)
      ST_ACCUM: begin
        chunk_idx = cnt;
        incr_sum  = (cnt != '0) && !flush;
        frame_cyc = FC_W'(cnt);
      end
      ST_SETTLE: frame_cyc = FC_W'(N_CHUNKS);
      ST_COMMIT: begin
        sample_ctl   = !flush;
        write_output = !flush;
        frame_cyc    = FC_W'(N_CHUNKS + 1);
      end
      default: ;
    endcase
    clk_adc_val = (state == ST_WAIT) || (frame_cyc < FC_W'(2)) ||
                  (frame_cyc == FC_W'(N_CHUNKS + 1));
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      history     <= '0;
      cnt         <= '0;
      frame_cnt_q <= '0;
    end else if (flush) begin
      history <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        history <= (history >> IN_W) | (HIST_W'(in_data) << (HIST_W - IN_W));
        cnt     <= '0;
      end else if (state == ST_ACCUM) begin
        cnt <= cnt + IDX_W'(1);
      end else begin
        cnt <= '0;
      end
      if (state == ST_COMMIT) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  emu_chunk_select #(
    .N_CHUNKS (N_CHUNKS),
    .CHUNK_W  (CHUNK_W)
  ) u_chunk_select (
    .history   (history),
    .chunk_idx (chunk_idx),
    .chunk     (chunk)
  );

endmodule
